mpi_credit_send_queue: RTL and testbench

//  Upstream feeder for the MPI sender endpoint. Buffers outgoing 64-bit messages with destination rank.

---
 rtl/metro_mpi_pkg.sv | 25 ++
 rtl/mpi_msg_fifo.sv | 59 +++++
 rtl/mpi_credit_send_queue.sv | 185 ++++++++++++++++++
 tb/tb_mpi_credit_send_queue.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/metro_mpi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : metro_mpi_pkg
//  Purpose  : Shared message type, send-side state encoding and default widths
//             for the MPI credit send queue.
//  Revision : 1.0
// ============================================================================
package metro_mpi_pkg;

    localparam int c_default_data_w = 64;
    localparam int c_default_rank_w = 32;

    typedef struct packed {
        logic [c_default_data_w-1:0] data;
        logic [c_default_rank_w-1:0] dest;
    } mpi_msg_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_CREDIT = 2'd1,
        PRESENT     = 2'd2
    } send_state_e;

endpackage
`default_nettype wire

// File: rtl/mpi_msg_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mpi_msg_fifo
//  Purpose  : Synchronous FIFO of messages; pointers carry one extra wrap bit
//             so full/empty fall out of a plain pointer compare.
//  Revision : 1.0
// ============================================================================
module mpi_msg_fifo
    import metro_mpi_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type MSG_T = mpi_msg_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  MSG_T                     wdata,
    input  logic                     pop,
    output MSG_T                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);

    MSG_T              r_mem [DEPTH];
    logic [c_aw:0]     r_wr_ptr;
    logic [c_aw:0]     r_rd_ptr;

    // Callers never push while full nor pop while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
        end
    end

    assign rdata = r_mem[r_rd_ptr[c_aw-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/mpi_credit_send_queue.sv
`default_nettype none
// ============================================================================
//  Module   : mpi_credit_send_queue
//  Purpose  : Buffers outgoing MPI messages and presents them to the sender
//             under credit-based flow control. Optional statistics counters
//             are enabled with METRO_MPI_SEND_STATS_EN.
//  Revision : 1.0
// ============================================================================
module mpi_credit_send_queue
    import metro_mpi_pkg::*;
#(
    parameter int DATA_W  = c_default_data_w,
    parameter int RANK_W  = c_default_rank_w,
    parameter int DEPTH   = 8,
    parameter int CREDITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [RANK_W-1:0]            in_dest,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [RANK_W-1:0]            out_dest,
    input  logic                         credit_return,
    output logic [$clog2(CREDITS+1)-1:0] credits_avail,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         err_credit_ovf
`ifdef METRO_MPI_SEND_STATS_EN
    ,
    output logic [31:0]                  stat_sent,
    output logic [31:0]                  stat_stall
`endif
);

    localparam int             c_cw          = $clog2(CREDITS+1);
    localparam logic [c_cw-1:0] c_credits_max = c_cw'(CREDITS);
    localparam logic [c_cw-1:0] c_credit_one  = c_cw'(1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RANK_W-1:0] dest;
    } msg_t;

    send_state_e      r_state;
    logic             r_out_valid;
    msg_t             r_out_msg;
    logic [c_cw-1:0]  r_credits;
    logic [c_cw-1:0]  w_credits_next;
    logic             r_err;

    msg_t             w_in_msg;
    msg_t             w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_fire;
    logic             w_ret_accept;

    assign w_in_msg = '{data: in_data, dest: in_dest};
    assign in_ready = !w_fifo_full;
    assign w_push   = in_valid && in_ready;
    assign w_fire   = r_out_valid && out_ready;

    // The head is taken either into an empty output register or on a fire.
    assign w_pop = !w_fifo_empty && ((r_state == IDLE) || w_fire);

    mpi_msg_fifo #(
        .DEPTH (DEPTH),
        .MSG_T (msg_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (w_in_msg),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (fifo_count)
    );

    // A return at the ceiling is only absorbed when a fire frees a slot.
    assign w_ret_accept = credit_return && ((r_credits != c_credits_max) || w_fire);

    always_comb begin
        w_credits_next = r_credits;
        if (w_fire && !w_ret_accept) begin
            w_credits_next = r_credits - c_credit_one;
        end else if (!w_fire && w_ret_accept) begin
            w_credits_next = r_credits + c_credit_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= c_credits_max;
            r_err     <= 1'b0;
        end else begin
            r_credits <= w_credits_next;
            if (credit_return && !w_ret_accept) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_msg   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        r_out_msg <= w_head;
                        if (r_credits != '0) begin
                            r_state     <= PRESENT;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT_CREDIT;
                        end
                    end
                end
                WAIT_CREDIT: begin
                    if (r_credits != '0) begin
                        r_state     <= PRESENT;
                        r_out_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (w_fire) begin
                        if (!w_fifo_empty) begin
                            r_out_msg <= w_head;
                            if (w_credits_next == '0) begin
                                r_state     <= WAIT_CREDIT;
                                r_out_valid <= 1'b0;
                            end
                        end else begin
                            r_state     <= IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_msg.data;
    assign out_dest       = r_out_msg.dest;
    assign credits_avail  = r_credits;
    assign err_credit_ovf = r_err;

`ifdef METRO_MPI_SEND_STATS_EN
    logic [31:0] r_stat_sent;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_sent  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_fire) begin
                r_stat_sent <= r_stat_sent + 32'd1;
            end
            if (r_state == WAIT_CREDIT) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_sent  = r_stat_sent;
    assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mpi_credit_send_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mpi_credit_send_queue
//  Purpose  : Self-checking bench for mpi_credit_send_queue with an ordered
//             message scoreboard. Build with METRO_MPI_SEND_STATS_EN to cover
//             the statistics outputs.
//  Revision : 1.0
// ============================================================================
module tb_mpi_credit_send_queue;

    localparam int DATA_W  = 64;
    localparam int RANK_W  = 32;
    localparam int DEPTH   = 8;
    localparam int CREDITS = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RANK_W-1:0] dest;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [RANK_W-1:0] in_dest;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RANK_W-1:0] out_dest;
    logic              credit_return;
    logic [2:0]        credits_avail;
    logic [3:0]        fifo_count;
    logic              err_credit_ovf;
`ifdef METRO_MPI_SEND_STATS_EN
    logic [31:0]       stat_sent;
    logic [31:0]       stat_stall;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_fires  = 0;
    int   msg_idx  = 0;
    exp_t sb[$];
    exp_t mon_exp;

    mpi_credit_send_queue #(
        .DATA_W  (DATA_W),
        .RANK_W  (RANK_W),
        .DEPTH   (DEPTH),
        .CREDITS (CREDITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_dest        (in_dest),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_dest       (out_dest),
        .credit_return  (credit_return),
        .credits_avail  (credits_avail),
        .fifo_count     (fifo_count),
        .err_credit_ovf (err_credit_ovf)
`ifdef METRO_MPI_SEND_STATS_EN
        ,
        .stat_sent      (stat_sent),
        .stat_stall     (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after posedge, so at negedge the handshakes that the
    // coming edge will complete are already settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_checks++;
                n_fires++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected: fired data=%h dest=%h, required no message", out_data, out_dest);
                end else begin
                    mon_exp = sb.pop_front();
                    if (out_data !== mon_exp.data || out_dest !== mon_exp.dest) begin
                        n_errors++;
                        $display("FAIL sb_order: got data=%h dest=%h, required data=%h dest=%h",
                                 out_data, out_dest, mon_exp.data, mon_exp.dest);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{data: in_data, dest: in_dest});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        in_dest       = '0;
        out_ready     = 1'b0;
        credit_return = 1'b0;
        step();
        step();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic push_msg(input logic [DATA_W-1:0] d, input logic [RANK_W-1:0] r);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = r;
        for (int i = 0; i < 100 && !done; i++) begin
            done = in_ready;
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL push_timeout: in_ready stayed 0, required 1 within 100 cycles");
        end
    endtask

    task automatic push_next();
        push_msg(64'hA5A5_0000_0000_1000 + 64'(msg_idx), 32'(msg_idx + 16));
        msg_idx++;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (sb.size() == 0 && !out_valid && fifo_count == 0 && credits_avail == 3'(CREDITS)) begin
                done = 1'b1;
            end else begin
                out_ready     = 1'b1;
                credit_return = (credits_avail != 3'(CREDITS)) || out_valid;
                step();
            end
        end
        credit_return = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL drain_timeout: %0d messages outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || fifo_count !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_flow: in_ready=%b out_valid=%b count=%0d, required 1 0 0", in_ready, out_valid, fifo_count);
        end
        n_checks++;
        if (out_data !== '0 || out_dest !== '0) begin
            n_errors++;
            $display("FAIL reset_out: data=%h dest=%h, required 0 0", out_data, out_dest);
        end
        n_checks++;
        if (credits_avail !== 3'd4 || err_credit_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_credit: credits=%0d err=%b, required 4 0", credits_avail, err_credit_ovf);
        end
    endtask

    task automatic test_single();
        int f0;
        do_reset();
        f0        = n_fires;
        out_ready = 1'b1;
        push_msg(64'h2, 32'h1);
        n_checks++;
        if (out_valid !== 1'b0 || fifo_count !== 4'd1) begin
            n_errors++;
            $display("FAIL single_queued: out_valid=%b count=%0d, required 0 1", out_valid, fifo_count);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h2 || out_dest !== 32'h1 || credits_avail !== 3'd4) begin
            n_errors++;
            $display("FAIL single_present: valid=%b data=%h dest=%h credits=%0d, required 1 2 1 4",
                     out_valid, out_data, out_dest, credits_avail);
        end
        step();
        n_checks++;
        if (credits_avail !== 3'd3 || out_valid !== 1'b0 || n_fires != f0 + 1) begin
            n_errors++;
            $display("FAIL single_fired: credits=%0d valid=%b fires=%0d, required 3 0 1",
                     credits_avail, out_valid, n_fires - f0);
        end
    endtask

    task automatic test_credit_stall();
        int f0;
        do_reset();
        f0        = n_fires;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_next();
        for (int i = 0; i < 8; i++) step();
        n_checks++;
        if (n_fires != f0 + 4 || out_valid !== 1'b0 || credits_avail !== 3'd0 || fifo_count !== 4'd1) begin
            n_errors++;
            $display("FAIL stall_wait: fires=%0d valid=%b credits=%0d count=%0d, required 4 0 0 1",
                     n_fires - f0, out_valid, credits_avail, fifo_count);
        end
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || credits_avail !== 3'd1) begin
            n_errors++;
            $display("FAIL stall_pulse1: valid=%b credits=%0d, required 0 1", out_valid, credits_avail);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hA5A5_0000_0000_1000 + 64'(msg_idx - 2)) begin
            n_errors++;
            $display("FAIL stall_pulse2: valid=%b data=%h, required 1 %h",
                     out_valid, out_data, 64'hA5A5_0000_0000_1000 + 64'(msg_idx - 2));
        end
        step();
        n_checks++;
        if (n_fires != f0 + 5 || out_valid !== 1'b0 || credits_avail !== 3'd0) begin
            n_errors++;
            $display("FAIL stall_fifth: fires=%0d valid=%b credits=%0d, required 5 0 0",
                     n_fires - f0, out_valid, credits_avail);
        end
`ifdef METRO_MPI_SEND_STATS_EN
        n_checks++;
        if (stat_sent !== 32'd5 || stat_stall == 32'd0) begin
            n_errors++;
            $display("FAIL stall_stats: sent=%0d stall=%0d, required 5 and nonzero", stat_sent, stat_stall);
        end
`endif
        drain();
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) push_next();
        n_checks++;
        if (in_ready !== 1'b0 || fifo_count !== 4'd8 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL full_state: in_ready=%b count=%0d valid=%b, required 0 8 1", in_ready, fifo_count, out_valid);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (fifo_count !== 4'd7) begin
            n_errors++;
            $display("FAIL full_first_pop: count=%0d, required 7", fifo_count);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 64'hA5A5_0000_0000_1000 + 64'(msg_idx);
            in_dest  = 32'(msg_idx + 16);
            msg_idx++;
            step();
            n_checks++;
            if (fifo_count !== 4'd7) begin
                n_errors++;
                $display("FAIL full_push_pop%0d: count=%0d, required 7", i, fifo_count);
            end
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_credit_ovf();
        do_reset();
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        n_checks++;
        if (credits_avail !== 3'd4 || err_credit_ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_set: credits=%0d err=%b, required 4 1", credits_avail, err_credit_ovf);
        end
        for (int i = 0; i < 3; i++) step();
        push_next();
        drain();
        n_checks++;
        if (err_credit_ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_sticky: err=%b, required 1", err_credit_ovf);
        end
        do_reset();
        n_checks++;
        if (err_credit_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_clear: err=%b, required 0", err_credit_ovf);
        end
    endtask

    task automatic test_fire_and_return();
        do_reset();
        for (int i = 0; i < 3; i++) push_next();
        out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (credits_avail !== 3'd2 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL fr_setup: credits=%0d valid=%b, required 2 1", credits_avail, out_valid);
        end
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        out_ready     = 1'b0;
        n_checks++;
        if (credits_avail !== 3'd2 || out_valid !== 1'b0 || err_credit_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL fr_same_cycle: credits=%0d valid=%b err=%b, required 2 0 0",
                     credits_avail, out_valid, err_credit_ovf);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) push_next();
        n_checks++;
        if (out_valid !== 1'b1 || fifo_count !== 4'd3) begin
            n_errors++;
            $display("FAIL mid_setup: valid=%b count=%0d, required 1 3", out_valid, fifo_count);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || fifo_count !== 4'd0 || credits_avail !== 3'd4) begin
            n_errors++;
            $display("FAIL mid_reset: valid=%b count=%0d credits=%0d, required 0 0 4",
                     out_valid, fifo_count, credits_avail);
        end
`ifdef METRO_MPI_SEND_STATS_EN
        n_checks++;
        if (stat_sent !== 32'd0 || stat_stall !== 32'd0) begin
            n_errors++;
            $display("FAIL mid_stats: sent=%0d stall=%0d, required 0 0", stat_sent, stat_stall);
        end
`endif
        rst = 1'b0;
        sb.delete();
        push_next();
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_credit_stall();
        test_full_push_pop();
        test_credit_ovf();
        test_fire_and_return();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
